wavetable_poly: RTL and testbench
=================================

// Module: wavetable_poly
// PURPOSE
//  Multi-voice successor to the single-voice wavetable oscillator. VOICES oscillators share one
//  external wavetable RAM port, time-multiplexed once per sample frame. Each voice has a
//  fractional phase accumulator, a bank select, a volume and an optional octave-down sub square.
//  The voices are volume-scaled, mixed and saturated into one sample that feeds the output DAC path.
// PARAMETERS
//  DATAWIDTH  16  sample width; RAM data is signed two's complement
//  ADDRWIDTH   8  wavetable address width (table depth 2^ADDRWIDTH)
//  FRACWIDTH   8  fractional phase bits
//  BANKWIDTH   2  wavetable bank select width
//  VOLWIDTH    5  per-voice volume width; unsigned, 16 = unity gain
//  VOICES      4  voice count, >=1; power of two
// PORTS
//  clk          in   1            system clock
//  rst          in   1            asynchronous reset, active-high
//  enable       in   1            1 = frames may run; 0 = abort/idle
//  sample_tick  in   1            one-cycle pulse that starts a frame
//  cfg_we       in   1            voice config write strobe
//  cfg_voice    in   clog2(VOICES) voice index for the write
//  cfg_inc      in   ADDR+FRAC    phase increment (8.8 at defaults)
//  cfg_bank     in   BANKWIDTH    wavetable bank for this voice
//  cfg_vol      in   VOLWIDTH     voice volume
//  cfg_sub_en   in   1            sub-oscillator enable
//  cfg_phase_clr in  1            with cfg_we: zero this voice's phase
//  RADDR        out  ADDRWIDTH    RAM read address
//  RBANK        out  BANKWIDTH    RAM bank select
//  RCLK         out  1            read strobe; RDATA is valid on the following clk edge
//  RDATA        in   DATAWIDTH    RAM read data
//  dout         out  DATAWIDTH    mixed, saturated sample
//  dout_valid   out  1            one-cycle pulse when dout updates
//  SUB_OUT      out  VOICES       per-voice sub square outputs
//  busy         out  1            frame in progress
//  overrun      out  1            sticky; set if a tick arrives while busy
// BEHAVIOUR
//  Reset values: all outputs 0; phases, inc, vol, bank, sub_en and the accumulator are 0.
//  FSM states:
//   IDLE: on sample_tick&enable, clear acc, v=0, go to ADDR.
//   ADDR: drive RADDR=phase[v][top ADDRWIDTH], RBANK=bank[v], RCLK=1; go to DATA.
//   DATA: RCLK=0; acc += RDATA*vol[v] (signed x unsigned); phase[v] += inc[v] mod 2^(ADDR+FRAC).
//         If v<VOICES-1: v++, go to ADDR. Otherwise go to OUT.
//   OUT:  dout = sat(acc >>> (VOLWIDTH-1)) to signed DATAWIDTH range; dout_valid=1; go to IDLE.
//  Latency: dout_valid occurs 2*VOICES+1 cycles after the tick edge; exactly VOICES RCLK pulses per frame.
//  busy = (state != IDLE). A sample_tick while busy is ignored and sets overrun (cleared only by rst).
//  Accumulator width = DATAWIDTH+VOLWIDTH+clog2(VOICES); it cannot overflow.
//  Sub oscillator: on a phase carry-out in DATA, SUB_OUT[v] toggles if sub_en[v]. sub_en[v]=0 forces SUB_OUT[v]=0.
//  Config writes take effect immediately. A same-cycle write to the voice in DATA: the update uses the
//   old inc; the new value is stored. cfg_phase_clr beats the concurrent phase update.
//  enable=0 mid-frame: FSM returns to IDLE next edge, RCLK=0, no dout_valid, dout holds, phases
//   already advanced keep their values.
//  rst mid-frame: immediate return to reset values; no dout_valid is produced.
//  RADDR/RBANK hold their last values outside ADDR.
// STRUCTURE
//  Package wavetable_pkg: width constants, state encoding, sat() function, clog2 helper.
//  Sub-module wt_mix_acc: signed MAC, clear/accumulate controls, saturating shifted output.
//  Top level holds the FSM, voice register file (arrays indexed by v), phase accumulators and SUB_OUT.
// TESTING
//  RAM model: RDATA <= {bank, addr}*3 on RCLK; VOICES=4 unless stated.
//  1 Voice0 inc=0x0100, vol=16, others vol=0; 3 ticks -> RADDR 0x00,0x01,0x02; dout 0,3,6.
//  2 inc=0x0080; 5 ticks -> RADDR 0,0,1,1,2; inc=0x4000 -> 0x00,0x40,0x80,0xC0,0x00;
//    SUB_OUT[0] toggles at the wrap with sub_en=1 and stays 0 with sub_en=0.
//  3 All voices vol=31, RDATA forced 0x7000 -> dout=0x7FFF; forced 0x9000 -> dout=0x8000.
//  4 Single tick -> 4 RCLK pulses, dout_valid at cycle 9 only; second tick at cycle 3 ignored, overrun=1.
//  5 cfg_we phase_clr for voice 2 during its DATA cycle -> phase[2]=0 next frame (RADDR 0x00).
//  6 rst at cycle 4 of a frame -> outputs 0 immediately, no dout_valid; enable=0 mid-frame -> abort,
//    dout unchanged, next frame runs normally.

Source files
------------

// File: rtl/wavetable_pkg.sv
// Shared widths, FSM encoding, voice config record and helpers for the polyphonic wavetable oscillator.
package wavetable_pkg;

    // Ceiling log2 for constant width derivation.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DATAWIDTH = 16;
    localparam int unsigned ADDRWIDTH = 8;
    localparam int unsigned FRACWIDTH = 8;
    localparam int unsigned BANKWIDTH = 2;
    localparam int unsigned VOLWIDTH  = 5;
    localparam int unsigned VOICES    = 4;

    localparam int unsigned VIDXW  = (VOICES > 1) ? clog2(VOICES) : 1;
    localparam int unsigned PHASEW = ADDRWIDTH + FRACWIDTH;
    // Sum of VOICES products of signed sample x unsigned volume never overflows this width.
    localparam int unsigned ACCW   = DATAWIDTH + VOLWIDTH + VIDXW;

    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'((2 ** (DATAWIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [PHASEW-1:0]    inc;
        logic [BANKWIDTH-1:0] bank;
        logic [VOLWIDTH-1:0]  vol;
        logic                 sub_en;
    } voice_cfg_t;

    // Clamp a wide signed value into the signed sample range.
    function automatic logic [DATAWIDTH-1:0] sat(input logic signed [ACCW-1:0] x);
        if (x > SAT_HI) begin
            return DATAWIDTH'(SAT_HI);
        end else if (x < SAT_LO) begin
            return DATAWIDTH'(SAT_LO);
        end else begin
            return DATAWIDTH'(x);
        end
    endfunction

endpackage

// File: rtl/wt_mix_acc.sv
// Signed multiply-accumulate of voice samples with a saturated, gain-normalised output.
module wt_mix_acc
    import wavetable_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        acc_en,
    input  logic signed [DATAWIDTH-1:0] sample,
    input  logic        [VOLWIDTH-1:0]  vol,
    output logic        [DATAWIDTH-1:0] sat_c
);

    logic signed [ACCW-1:0]   acc_q;
    logic signed [ACCW-1:0]   acc_d;
    logic signed [ACCW-1:0]   prod_c;
    logic signed [ACCW-1:0]   shifted_c;
    logic signed [VOLWIDTH:0] vol_s;

    // Next accumulator value and the scaled, saturated view of the current one.
    always_comb begin
        vol_s     = {1'b0, vol};
        prod_c    = ACCW'(sample) * ACCW'(vol_s);
        acc_d     = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + prod_c;
        end
        // Volume 16 is unity, so drop VOLWIDTH-1 fraction bits.
        shifted_c = acc_q >>> (VOLWIDTH - 1);
        sat_c     = sat(shifted_c);
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/wavetable_poly.sv
// Polyphonic wavetable oscillator: VOICES voices share one RAM port, mixed once per sample frame.
module wavetable_poly
    import wavetable_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sample_tick,
    input  logic                 cfg_we,
    input  logic [VIDXW-1:0]     cfg_voice,
    input  logic [PHASEW-1:0]    cfg_inc,
    input  logic [BANKWIDTH-1:0] cfg_bank,
    input  logic [VOLWIDTH-1:0]  cfg_vol,
    input  logic                 cfg_sub_en,
    input  logic                 cfg_phase_clr,
    output logic [ADDRWIDTH-1:0] RADDR,
    output logic [BANKWIDTH-1:0] RBANK,
    output logic                 RCLK,
    input  logic [DATAWIDTH-1:0] RDATA,
    output logic [DATAWIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic [VOICES-1:0]    SUB_OUT,
    output logic                 busy,
    output logic                 overrun
);

    state_e               state_q, state_d;
    logic [VIDXW-1:0]     v_q, v_d;
    voice_cfg_t           cfg_q   [VOICES];
    voice_cfg_t           cfg_d   [VOICES];
    logic [PHASEW-1:0]    phase_q [VOICES];
    logic [PHASEW-1:0]    phase_d [VOICES];
    logic [VOICES-1:0]    sub_q, sub_d;
    logic [ADDRWIDTH-1:0] raddr_q, raddr_d;
    logic [BANKWIDTH-1:0] rbank_q, rbank_d;
    logic                 rclk_q, rclk_d;
    logic [DATAWIDTH-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 mac_clr, mac_en;
    logic [DATAWIDTH-1:0] mix_sat_c;
    logic [PHASEW:0]      sum_c;
    logic                 wr_c;

    wt_mix_acc u_mix (
        .clk    (clk),
        .rst    (rst),
        .clr    (mac_clr),
        .acc_en (mac_en),
        .sample (RDATA),
        .vol    (cfg_q[v_q].vol),
        .sat_c  (mix_sat_c)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: dropping enable aborts any frame back to idle.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (sample_tick) state_d = ST_ADDR;
                ST_ADDR: state_d = ST_DATA;
                ST_DATA: state_d = (v_q == VIDXW'(VOICES - 1)) ? ST_OUT : ST_ADDR;
                ST_OUT:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Voice register file, phase accumulators and sub squares; config writes override frame updates.
    always_comb begin
        sum_c = '0;
        wr_c  = 1'b0;
        sub_d = sub_q;
        for (int i = 0; i < VOICES; i++) begin
            cfg_d[i]   = cfg_q[i];
            phase_d[i] = phase_q[i];
            wr_c       = cfg_we && (cfg_voice == VIDXW'(i));
            if ((state_q == ST_DATA) && enable && (v_q == VIDXW'(i))) begin
                sum_c      = {1'b0, phase_q[i]} + {1'b0, cfg_q[i].inc};
                phase_d[i] = sum_c[PHASEW-1:0];
                if (sum_c[PHASEW]) begin
                    sub_d[i] = ~sub_q[i];
                end
            end
            if (wr_c) begin
                cfg_d[i].inc    = cfg_inc;
                cfg_d[i].bank   = cfg_bank;
                cfg_d[i].vol    = cfg_vol;
                cfg_d[i].sub_en = cfg_sub_en;
                if (cfg_phase_clr) begin
                    phase_d[i] = '0;
                end
            end
            if (!cfg_d[i].sub_en) begin
                sub_d[i] = 1'b0;
            end
        end
    end

    // Outputs and sequencing controls derived from current and next state.
    always_comb begin
        v_d          = v_q;
        raddr_d      = raddr_q;
        rbank_d      = rbank_q;
        rclk_d       = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        overrun_d    = overrun_q | (sample_tick & (state_q != ST_IDLE));
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_ADDR) begin
                    v_d     = '0;
                    mac_clr = 1'b1;
                end
            end
            ST_DATA: begin
                if (enable) begin
                    mac_en = 1'b1;
                    if (state_d == ST_ADDR) begin
                        v_d = v_q + VIDXW'(1);
                    end
                end
            end
            ST_OUT: begin
                if (enable) begin
                    dout_d       = mix_sat_c;
                    dout_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
        // Present the read request for the coming ADDR cycle.
        if (state_d == ST_ADDR) begin
            rclk_d  = 1'b1;
            raddr_d = phase_d[v_d][PHASEW-1 -: ADDRWIDTH];
            rbank_d = cfg_d[v_d].bank;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q          <= '0;
            sub_q        <= '0;
            raddr_q      <= '0;
            rbank_q      <= '0;
            rclk_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                cfg_q[i]   <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            v_q          <= v_d;
            sub_q        <= sub_d;
            raddr_q      <= raddr_d;
            rbank_q      <= rbank_d;
            rclk_q       <= rclk_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < VOICES; i++) begin
                cfg_q[i]   <= cfg_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign RADDR      = raddr_q;
    assign RBANK      = rbank_q;
    assign RCLK       = rclk_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign SUB_OUT    = sub_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_wavetable_poly.sv
// Self-checking bench for wavetable_poly: constant vector table, corner sequences and a random frame model.
module tb_wavetable_poly;
    import wavetable_pkg::*;

    localparam int FRAME_CYC = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 sample_tick;
    logic                 cfg_we;
    logic [VIDXW-1:0]     cfg_voice;
    logic [PHASEW-1:0]    cfg_inc;
    logic [BANKWIDTH-1:0] cfg_bank;
    logic [VOLWIDTH-1:0]  cfg_vol;
    logic                 cfg_sub_en;
    logic                 cfg_phase_clr;
    logic [ADDRWIDTH-1:0] RADDR;
    logic [BANKWIDTH-1:0] RBANK;
    logic                 RCLK;
    logic [DATAWIDTH-1:0] RDATA = '0;
    logic [DATAWIDTH-1:0] dout;
    logic                 dout_valid;
    logic [VOICES-1:0]    SUB_OUT;
    logic                 busy;
    logic                 overrun;

    wavetable_poly dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc), .cfg_bank(cfg_bank),
        .cfg_vol(cfg_vol), .cfg_sub_en(cfg_sub_en), .cfg_phase_clr(cfg_phase_clr),
        .RADDR(RADDR), .RBANK(RBANK), .RCLK(RCLK), .RDATA(RDATA),
        .dout(dout), .dout_valid(dout_valid), .SUB_OUT(SUB_OUT), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // External wavetable RAM: data = {bank, addr} * 3, or a forced constant.
    logic        force_en = 1'b0;
    logic [15:0] force_val = '0;
    always @(posedge clk) begin
        if (RCLK) RDATA <= force_en ? force_val : 16'({RBANK, RADDR} * 3);
    end

    // Reference model state.
    int mphase [VOICES];
    int minc   [VOICES];
    int mbank  [VOICES];
    int mvol   [VOICES];
    bit msub_en[VOICES];
    bit msub   [VOICES];
    int e_addr [VOICES];
    int e_bank [VOICES];
    int e_dout;
    int e_sub;

    // Observations from the last frame.
    int          n_rclk, dv_n, dv_cyc;
    logic [15:0] dv_val;
    int          got_addr[8];
    int          got_bank[8];
    int          snap;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int v = 0; v < VOICES; v++) begin
            mphase[v] = 0; minc[v] = 0; mbank[v] = 0; mvol[v] = 0;
            msub_en[v] = 0; msub[v] = 0;
        end
    endtask

    // One frame over the first nv voices: expected reads and mix, then advance phases.
    task automatic mdl_frame(input int nv);
        int acc;
        int sum;
        logic signed [15:0] d16;
        acc = 0;
        for (int v = 0; v < nv; v++) begin
            e_addr[v] = mphase[v] / 256;
            e_bank[v] = mbank[v];
            d16 = force_en ? force_val : 16'((mbank[v] * 256 + e_addr[v]) * 3);
            acc = acc + int'(d16) * mvol[v];
            sum = mphase[v] + minc[v];
            if (sum >= 65536 && msub_en[v]) msub[v] = ~msub[v];
            mphase[v] = sum % 65536;
        end
        acc = acc >>> 4;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        e_dout = acc & 'hFFFF;
        e_sub = 0;
        for (int v = 0; v < VOICES; v++) if (msub_en[v] && msub[v]) e_sub = e_sub | (1 << v);
    endtask

    task automatic cfg(input int v, input int inc, input int bank, input int vol, input bit sub_en, input bit clr);
        @(negedge clk);
        cfg_we = 1; cfg_voice = VIDXW'(v); cfg_inc = PHASEW'(inc); cfg_bank = BANKWIDTH'(bank);
        cfg_vol = VOLWIDTH'(vol); cfg_sub_en = sub_en; cfg_phase_clr = clr;
        @(negedge clk);
        cfg_we = 0; cfg_phase_clr = 0;
        minc[v] = inc; mbank[v] = bank; mvol[v] = vol; msub_en[v] = sub_en;
        if (clr) mphase[v] = 0;
        if (!sub_en) msub[v] = 0;
    endtask

    // Issue a tick and observe a bounded window; optional mid-frame events keyed to cycle numbers.
    task automatic frame(input int tick2_at, input int abort_at, input int clr_at, input int clr_v, input int rst_at);
        n_rclk = 0; dv_n = 0; dv_cyc = -1; dv_val = '0;
        @(negedge clk);
        sample_tick = 1;
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            sample_tick = 0; cfg_we = 0; cfg_phase_clr = 0;
            if (RCLK) begin
                if (n_rclk < 8) begin
                    got_addr[n_rclk] = int'(RADDR);
                    got_bank[n_rclk] = int'(RBANK);
                end
                n_rclk++;
            end
            if (dout_valid) begin dv_n++; dv_cyc = c; dv_val = dout; end
            if (c == tick2_at) sample_tick = 1;
            if (c == abort_at) enable = 0;
            if (c == clr_at) begin
                cfg_we = 1; cfg_voice = VIDXW'(clr_v); cfg_inc = PHASEW'(minc[clr_v]);
                cfg_bank = BANKWIDTH'(mbank[clr_v]); cfg_vol = VOLWIDTH'(mvol[clr_v]);
                cfg_sub_en = msub_en[clr_v]; cfg_phase_clr = 1;
            end
            if (c == rst_at) begin
                rst = 1;
                #1;
                snap = int'({RADDR, RBANK, RCLK, dout, dout_valid, SUB_OUT, busy, overrun});
            end
            if (c == rst_at + 2) rst = 0;
        end
        enable = 1;
    endtask

    task automatic run_frame();
        frame(-1, -1, -1, 0, -1);
    endtask

    task automatic check_full(input string tag);
        chk({tag, "_rclk_cnt"}, n_rclk, VOICES);
        for (int v = 0; v < VOICES; v++) begin
            chk($sformatf("%s_raddr_v%0d", tag, v), got_addr[v], e_addr[v]);
            chk($sformatf("%s_rbank_v%0d", tag, v), got_bank[v], e_bank[v]);
        end
        chk({tag, "_dv_cnt"}, dv_n, 1);
        chk({tag, "_dv_cycle"}, dv_cyc, 2 * VOICES + 1);
        chk({tag, "_dout"}, int'(dv_val), e_dout);
        chk({tag, "_sub_out"}, int'(SUB_OUT), e_sub);
        chk({tag, "_busy_end"}, int'(busy), 0);
    endtask

    typedef struct {
        bit          cfg;
        int          inc;
        bit          sub_en;
        int          exp_addr;
        int          exp_dout;
        int          exp_sub;
    } row_t;

    row_t rows[18];

    initial begin
        int dout_before;

        // Voice 0 only, vol 16, bank 0; a cfg row clears phase first.
        rows[0]  = '{1, 'h0100, 0, 'h00, 0,   0};
        rows[1]  = '{0, 'h0100, 0, 'h01, 3,   0};
        rows[2]  = '{0, 'h0100, 0, 'h02, 6,   0};
        rows[3]  = '{1, 'h0080, 0, 'h00, 0,   0};
        rows[4]  = '{0, 'h0080, 0, 'h00, 0,   0};
        rows[5]  = '{0, 'h0080, 0, 'h01, 3,   0};
        rows[6]  = '{0, 'h0080, 0, 'h01, 3,   0};
        rows[7]  = '{0, 'h0080, 0, 'h02, 6,   0};
        rows[8]  = '{1, 'h4000, 1, 'h00, 0,   0};
        rows[9]  = '{0, 'h4000, 1, 'h40, 192, 0};
        rows[10] = '{0, 'h4000, 1, 'h80, 384, 0};
        rows[11] = '{0, 'h4000, 1, 'hC0, 576, 1};
        rows[12] = '{0, 'h4000, 1, 'h00, 0,   1};
        rows[13] = '{1, 'h4000, 0, 'h00, 0,   0};
        rows[14] = '{0, 'h4000, 0, 'h40, 192, 0};
        rows[15] = '{0, 'h4000, 0, 'h80, 384, 0};
        rows[16] = '{0, 'h4000, 0, 'hC0, 576, 0};
        rows[17] = '{0, 'h4000, 0, 'h00, 0,   0};

        rst = 1; enable = 1; sample_tick = 0; cfg_we = 0; cfg_voice = '0; cfg_inc = '0;
        cfg_bank = '0; cfg_vol = '0; cfg_sub_en = 0; cfg_phase_clr = 0;
        mdl_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_raddr", int'(RADDR), 0);
        chk("rst_rclk", int'(RCLK), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_sub_out", int'(SUB_OUT), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Single-voice vector table.
        for (int r = 0; r < 18; r++) begin
            if (rows[r].cfg) cfg(0, rows[r].inc, 0, 16, rows[r].sub_en, 1);
            mdl_frame(VOICES);
            run_frame();
            chk($sformatf("tbl%0d_raddr", r), got_addr[0], rows[r].exp_addr);
            chk($sformatf("tbl%0d_dout", r), int'(dv_val), rows[r].exp_dout);
            chk($sformatf("tbl%0d_sub0", r), int'(SUB_OUT[0]), rows[r].exp_sub);
            chk($sformatf("tbl%0d_dv_cnt", r), dv_n, 1);
        end

        // Second tick while busy is ignored and latches overrun.
        chk("ovr_before", int'(overrun), 0);
        mdl_frame(VOICES);
        frame(2, -1, -1, 0, -1);
        chk("ovr_rclk_cnt", n_rclk, 4);
        chk("ovr_dv_cnt", dv_n, 1);
        chk("ovr_dv_cycle", dv_cyc, 9);
        chk("ovr_set", int'(overrun), 1);
        check_full("ovr");

        // Saturation at both rails.
        for (int v = 0; v < VOICES; v++) cfg(v, minc[v], mbank[v], 31, msub_en[v], 0);
        force_en = 1; force_val = 16'h7000;
        mdl_frame(VOICES);
        run_frame();
        chk("sat_pos", int'(dv_val), 'h7FFF);
        check_full("satp");
        force_val = 16'h9000;
        mdl_frame(VOICES);
        run_frame();
        chk("sat_neg", int'(dv_val), 'h8000);
        check_full("satn");
        force_en = 0;

        // Phase clear of voice 2 landing in its own DATA cycle.
        cfg(2, 'h0100, 1, 16, 0, 1);
        mdl_frame(VOICES);
        run_frame();
        check_full("pclr_a");
        mdl_frame(VOICES);
        frame(-1, -1, 5, 2, -1);
        check_full("pclr_b");
        chk("pclr_b_raddr2", got_addr[2], 1);
        mphase[2] = 0;
        mdl_frame(VOICES);
        run_frame();
        chk("pclr_c_raddr2", got_addr[2], 0);
        check_full("pclr_c");

        // Randomised configurations against the model.
        for (int k = 0; k < 24; k++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                cfg($urandom_range(0, VOICES - 1), $urandom_range(0, 65535), $urandom_range(0, 3),
                    $urandom_range(0, 31), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
            mdl_frame(VOICES);
            run_frame();
            check_full($sformatf("rnd%0d", k));
        end

        // Abort by dropping enable during voice 1 ADDR: voice 0 already advanced.
        cfg(0, 'h1234, 2, 20, 1, 0);
        mdl_frame(VOICES);
        run_frame();
        check_full("pre_abort");
        dout_before = int'(dout);
        mdl_frame(1);
        frame(-1, 2, -1, 0, -1);
        chk("abort_dv_cnt", dv_n, 0);
        chk("abort_dout_hold", int'(dout), dout_before);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rclk_cnt", n_rclk, 2);
        mdl_frame(VOICES);
        run_frame();
        check_full("post_abort");

        // Reset in the middle of a frame.
        mdl_frame(VOICES);
        frame(-1, -1, -1, 0, 3);
        chk("midrst_outputs", snap, 0);
        chk("midrst_dv_cnt", dv_n, 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_dout", int'(dout), 0);
        mdl_reset();
        cfg(0, 'h0100, 1, 16, 0, 0);
        mdl_frame(VOICES);
        run_frame();
        check_full("after_rst");
        mdl_frame(VOICES);
        run_frame();
        check_full("after_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
